jtgng_rom_arb: RTL and testbench



---
 rtl/jtgng_rom_pkg.sv | 34 +++
 rtl/jtgng_rom_slot.sv | 55 +++++
 rtl/jtgng_rom_arb.sv | 154 +++++++++++++++
 tb/tb_jtgng_rom_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtgng_rom_pkg.sv
// rtl/jtgng_rom_pkg.sv - shared types, defaults and round-robin helper for the ROM arbiter
package jtgng_rom_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_RDY
  } arb_state_e;

  localparam int DEF_AW    = 22;
  localparam int DEF_DW    = 32;
  localparam int MAX_SLOTS = 8;

  // First set bit of req at or after ptr, wrapping at n-1 -> 0. Returns 0 when req is empty.
  function automatic logic [2:0] rr_pick(input logic [MAX_SLOTS-1:0] req,
                                         input logic [2:0] ptr,
                                         input int n);
    logic [2:0] sel;
    logic       found;
    int         idx;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_SLOTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && !found && req[idx[2:0]]) begin
        found = 1'b1;
        sel   = idx[2:0];
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/jtgng_rom_slot.sv
// rtl/jtgng_rom_slot.sv - one-entry cache for a single ROM requester
module jtgng_rom_slot
  import jtgng_rom_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          fill_we,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  input  logic          invalidate,
  output logic          hit,
  output logic          ok,
  output logic [DW-1:0] dout
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  // Cache entry update: fill loads a new line, invalidate wins over fill
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (fill_we) begin
      valid_d = 1'b1;
      addr_d  = fill_addr;
      data_d  = fill_data;
    end
    if (invalidate) valid_d = 1'b0;
  end

  // Cache entry registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hit  = valid_q && (addr_q == addr);
  assign ok   = cs && hit;
  assign dout = data_q;

endmodule

// File: rtl/jtgng_rom_arb.sv
// rtl/jtgng_rom_arb.sv - per-slot ROM caches sharing one SDRAM read port via round-robin
module jtgng_rom_arb
  import jtgng_rom_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                data_rdy,
  input  logic [DW-1:0]       data_read,
  output logic                refresh_en
);

  localparam int PW = $clog2(SLOTS);

  arb_state_e      state_q, state_d;
  logic [PW-1:0]   win_q, win_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic            req_q, req_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            refresh_q, refresh_d;
  logic            discard_q, discard_d;

  logic [SLOTS-1:0]     hit;
  logic [SLOTS-1:0]     pending;
  logic [SLOTS-1:0]     fill_we_v;
  logic                 inval;
  logic [MAX_SLOTS-1:0] pend8;
  logic [PW-1:0]        pick;
  logic                 capture;
  logic [AW-1:0]        addr_arr [SLOTS];

  genvar gi;
  generate
    for (gi = 0; gi < SLOTS; gi++) begin : g_slot
      assign addr_arr[gi] = slot_addr[gi*AW +: AW];
      jtgng_rom_slot #(
        .AW(AW),
        .DW(DW)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .cs         (slot_cs[gi]),
        .addr       (addr_arr[gi]),
        .fill_we    (fill_we_v[gi]),
        .fill_addr  (addr_q),
        .fill_data  (data_read),
        .invalidate (inval),
        .hit        (hit[gi]),
        .ok         (slot_ok[gi]),
        .dout       (slot_dout[gi*DW +: DW])
      );
    end
  endgenerate

  assign pending = slot_cs & ~hit;

  // Winner selection among missing slots, starting at the round-robin pointer
  always_comb begin
    pend8             = '0;
    pend8[SLOTS-1:0]  = pending;
    pick              = PW'(rr_pick(pend8, 3'(rr_q), SLOTS));
  end

  // Data returns either together with the ack or later while waiting for it
  assign capture = ((state_q == WAIT_ACK) && sdram_ack && data_rdy) ||
                   ((state_q == WAIT_RDY) && data_rdy);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      win_q     <= '0;
      rr_q      <= '0;
      req_q     <= 1'b0;
      addr_q    <= '0;
      refresh_q <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      rr_q      <= rr_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      refresh_q <= refresh_d;
      discard_q <= discard_d;
    end
  end

  // Next-state logic: one SDRAM read in flight at a time
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (!downloading && (|pending)) state_d = WAIT_ACK;
      WAIT_ACK: if (sdram_ack) state_d = data_rdy ? IDLE : WAIT_RDY;
      WAIT_RDY: if (data_rdy) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Request, capture, invalidate and refresh outputs per state
  always_comb begin
    req_d     = req_q;
    addr_d    = addr_q;
    win_d     = win_q;
    rr_d      = rr_q;
    discard_d = discard_q;
    refresh_d = 1'b0;
    inval     = 1'b0;
    fill_we_v = '0;
    case (state_q)
      IDLE: begin
        discard_d = 1'b0;
        refresh_d = !downloading && (pending == '0);
        if (downloading) begin
          inval = 1'b1;
          req_d = 1'b0;
        end else if (|pending) begin
          win_d  = pick;
          addr_d = addr_arr[pick];
          req_d  = 1'b1;
        end
      end
      WAIT_ACK: begin
        if (downloading) discard_d = 1'b1;
        if (sdram_ack) req_d = 1'b0;
      end
      WAIT_RDY: begin
        if (downloading) discard_d = 1'b1;
      end
      default: req_d = 1'b0;
    endcase
    // A fetch overlapped by a ROM download is completed but never cached
    if (capture) begin
      if (!discard_q && !downloading) fill_we_v[win_q] = 1'b1;
      rr_d = (win_q == PW'(SLOTS-1)) ? '0 : win_q + PW'(1);
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = addr_q;
  assign refresh_en = refresh_q;

endmodule

// File: tb/tb_jtgng_rom_arb.sv
// tb/tb_jtgng_rom_arb.sv - scoreboard bench for the ROM arbiter
module tb_jtgng_rom_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 22;
  localparam int DW    = 32;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                downloading = 1'b0;
  logic [SLOTS-1:0]    slot_cs = '0;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack = 1'b0;
  logic                data_rdy = 1'b0;
  logic [DW-1:0]       data_read = '0;
  logic                refresh_en;

  int n_cmp = 0;
  int n_err = 0;
  logic [AW-1:0] exp_q [$];

  jtgng_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .downloading (downloading),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en)
  );

  always #10 clk = ~clk;

  // SDRAM content model: a fixed function of the word address
  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return 32'hDEADBEEF ^ {10'd0, a} ^ 32'h00000100;
  endfunction

  function automatic logic [DW-1:0] dout_of(input int s);
    return slot_dout[s*DW +: DW];
  endfunction

  task automatic set_addr(input int s, input logic [AW-1:0] a);
    slot_addr[s*AW +: AW] = a;
  endtask

  task automatic apply_reset();
    slot_cs     = '0;
    downloading = 1'b0;
    sdram_ack   = 1'b0;
    data_rdy    = 1'b0;
    rst         = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Waits for a request, pops the scoreboard and compares the address
  task automatic wait_req(output bit got, output logic [AW-1:0] a);
    logic [AW-1:0] e;
    got = 1'b0;
    a   = '0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (sdram_req) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL req_timeout: sdram_req=0 after 50 cycles, required 1");
      return;
    end
    a = sdram_addr;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_req: sdram_addr=%h, no request expected", a);
    end else begin
      e = exp_q.pop_front();
      if (a !== e) begin
        n_err++;
        $display("FAIL req_addr: sdram_addr=%h, required %h", a, e);
      end
    end
  endtask

  // Controller model: ack after ack_dly cycles, data rdy_dly cycles after the ack
  task automatic do_fetch(input int ack_dly, input int rdy_dly, input int chg_slot,
                          input logic [AW-1:0] chg_addr, input bit dl_mid);
    bit            got;
    logic [AW-1:0] a;
    wait_req(got, a);
    if (!got) return;
    repeat (ack_dly) begin
      @(negedge clk);
      n_cmp++;
      if (sdram_req !== 1'b1 || sdram_addr !== a) begin
        n_err++;
        $display("FAIL req_hold: req=%b addr=%h, required req=1 addr=%h", sdram_req, sdram_addr, a);
      end
    end
    sdram_ack = 1'b1;
    if (rdy_dly == 0) begin
      data_rdy  = 1'b1;
      data_read = mem(a);
    end
    @(negedge clk);
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    if (rdy_dly > 0) begin
      if (chg_slot >= 0) set_addr(chg_slot, chg_addr);
      if (dl_mid) downloading = 1'b1;
      n_cmp++;
      if (sdram_req !== 1'b0) begin
        n_err++;
        $display("FAIL req_drop: sdram_req=%b after ack, required 0", sdram_req);
      end
      repeat (rdy_dly - 1) @(negedge clk);
      data_rdy  = 1'b1;
      data_read = mem(a);
      @(negedge clk);
      data_rdy = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (slot_ok !== '0 || sdram_req !== 1'b0 || sdram_addr !== '0 ||
        refresh_en !== 1'b0 || slot_dout !== '0) begin
      n_err++;
      $display("FAIL reset_state: ok=%b req=%b addr=%h ref=%b dout=%h, required all 0",
               slot_ok, sdram_req, sdram_addr, refresh_en, slot_dout);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_miss();
    apply_reset();
    set_addr(0, 22'h00100);
    exp_q.push_back(22'h00100);
    slot_cs = 4'b0001;
    do_fetch(2, 4, -1, '0, 1'b0);
    n_cmp++;
    if (slot_ok[0] !== 1'b1 || dout_of(0) !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL single_fill: ok0=%b dout0=%h, required 1 deadbeef", slot_ok[0], dout_of(0));
    end
    repeat (5) begin
      @(negedge clk);
      n_cmp++;
      if (sdram_req !== 1'b0 || slot_ok[0] !== 1'b1) begin
        n_err++;
        $display("FAIL single_hit: req=%b ok0=%b, required req=0 ok0=1", sdram_req, slot_ok[0]);
      end
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < SLOTS; i++) set_addr(i, 22'h00200 + 22'(i * 4));
    exp_q.push_back(22'h00200);
    exp_q.push_back(22'h00204);
    slot_cs = 4'b1111;
    do_fetch(1, 1, -1, '0, 1'b0);
    do_fetch(1, 1, -1, '0, 1'b0);
    set_addr(0, 22'h00300);
    exp_q.push_back(22'h00208);
    exp_q.push_back(22'h0020C);
    exp_q.push_back(22'h00300);
    repeat (3) do_fetch(1, 1, -1, '0, 1'b0);
    n_cmp++;
    if (slot_ok !== 4'b1111 || dout_of(0) !== mem(22'h00300) || dout_of(3) !== mem(22'h0020C)) begin
      n_err++;
      $display("FAIL rr_fill: ok=%b dout0=%h dout3=%h, required 1111 %h %h",
               slot_ok, dout_of(0), dout_of(3), mem(22'h00300), mem(22'h0020C));
    end
  endtask

  task automatic test_ack_rdy_same();
    apply_reset();
    set_addr(2, 22'h00400);
    exp_q.push_back(22'h00400);
    slot_cs = 4'b0100;
    do_fetch(0, 0, -1, '0, 1'b0);
    n_cmp++;
    if (slot_ok[2] !== 1'b1 || dout_of(2) !== mem(22'h00400) || sdram_req !== 1'b0) begin
      n_err++;
      $display("FAIL same_cycle_fill: ok2=%b dout2=%h req=%b, required 1 %h 0",
               slot_ok[2], dout_of(2), sdram_req, mem(22'h00400));
    end
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (sdram_req !== 1'b0) begin
        n_err++;
        $display("FAIL same_cycle_norefetch: sdram_req=%b, required 0", sdram_req);
      end
    end
    n_cmp++;
    if (refresh_en !== 1'b1) begin
      n_err++;
      $display("FAIL same_cycle_refresh: refresh_en=%b, required 1", refresh_en);
    end
  endtask

  task automatic test_addr_change();
    apply_reset();
    set_addr(1, 22'h000A0);
    exp_q.push_back(22'h000A0);
    slot_cs = 4'b0010;
    do_fetch(1, 3, 1, 22'h000A4, 1'b0);
    n_cmp++;
    if (slot_ok[1] !== 1'b0 || dout_of(1) !== mem(22'h000A0)) begin
      n_err++;
      $display("FAIL addr_change_old: ok1=%b dout1=%h, required 0 %h", slot_ok[1], dout_of(1), mem(22'h000A0));
    end
    exp_q.push_back(22'h000A4);
    do_fetch(1, 1, -1, '0, 1'b0);
    n_cmp++;
    if (slot_ok[1] !== 1'b1 || dout_of(1) !== mem(22'h000A4)) begin
      n_err++;
      $display("FAIL addr_change_new: ok1=%b dout1=%h, required 1 %h", slot_ok[1], dout_of(1), mem(22'h000A4));
    end
  endtask

  task automatic test_download_refresh();
    apply_reset();
    set_addr(0, 22'h00500);
    exp_q.push_back(22'h00500);
    slot_cs = 4'b0001;
    do_fetch(1, 1, -1, '0, 1'b0);
    set_addr(3, 22'h00600);
    exp_q.push_back(22'h00600);
    slot_cs = 4'b1001;
    do_fetch(1, 2, -1, '0, 1'b1);
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (sdram_req !== 1'b0 || refresh_en !== 1'b0) begin
        n_err++;
        $display("FAIL dl_quiet: req=%b ref=%b, required 0 0", sdram_req, refresh_en);
      end
    end
    n_cmp++;
    if (slot_ok !== 4'b0000) begin
      n_err++;
      $display("FAIL dl_invalidate: ok=%b, required 0000", slot_ok);
    end
    downloading = 1'b0;
    slot_cs     = 4'b0000;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (refresh_en !== 1'b1) begin
      n_err++;
      $display("FAIL refresh_idle: refresh_en=%b, required 1", refresh_en);
    end
    exp_q.push_back(22'h00500);
    slot_cs = 4'b0001;
    @(negedge clk);
    n_cmp++;
    if (refresh_en !== 1'b0) begin
      n_err++;
      $display("FAIL refresh_miss: refresh_en=%b, required 0", refresh_en);
    end
    do_fetch(1, 1, -1, '0, 1'b0);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (refresh_en !== 1'b1 || slot_ok[0] !== 1'b1) begin
      n_err++;
      $display("FAIL refresh_hit: refresh_en=%b ok0=%b, required 1 1", refresh_en, slot_ok[0]);
    end
  endtask

  task automatic test_reset_mid_fetch();
    bit            got;
    logic [AW-1:0] a;
    apply_reset();
    set_addr(0, 22'h00700);
    set_addr(1, 22'h00710);
    exp_q.push_back(22'h00700);
    slot_cs = 4'b0001;
    do_fetch(1, 1, -1, '0, 1'b0);
    n_cmp++;
    if (slot_ok !== 4'b0001) begin
      n_err++;
      $display("FAIL pre_reset_fill: ok=%b, required 0001", slot_ok);
    end
    exp_q.push_back(22'h00710);
    slot_cs = 4'b0011;
    wait_req(got, a);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (sdram_req !== 1'b0 || slot_ok !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_mid: req=%b ok=%b, required 0 0000", sdram_req, slot_ok);
    end
    slot_cs   = 4'b0000;
    rst       = 1'b0;
    sdram_ack = 1'b1;
    data_rdy  = 1'b1;
    data_read = 32'h12345678;
    @(negedge clk);
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    slot_cs   = 4'b0011;
    #1;
    n_cmp++;
    if (slot_ok !== 4'b0000 || sdram_req !== 1'b0) begin
      n_err++;
      $display("FAIL stray_rdy: ok=%b req=%b, required 0000 0", slot_ok, sdram_req);
    end
    exp_q.push_back(22'h00700);
    exp_q.push_back(22'h00710);
    do_fetch(1, 1, -1, '0, 1'b0);
    do_fetch(1, 1, -1, '0, 1'b0);
    n_cmp++;
    if (slot_ok !== 4'b0011 || dout_of(0) !== mem(22'h00700) || dout_of(1) !== mem(22'h00710)) begin
      n_err++;
      $display("FAIL post_reset_fill: ok=%b dout0=%h dout1=%h, required 0011 %h %h",
               slot_ok, dout_of(0), dout_of(1), mem(22'h00700), mem(22'h00710));
    end
  endtask

  initial begin
    test_reset();
    test_single_miss();
    test_round_robin();
    test_ack_rdy_same();
    test_addr_change();
    test_download_refresh();
    test_reset_mid_fetch();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d requests outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
